// File: rtl/insn_fetch.sv
// ---------------------------------------------------------------------------
// insn_fetch -- instruction fetch stage
//
// Reads instruction words over a request/grant/response handshake and hands
// each word, together with its PC, to decode. One extra word can be held
// while decode is stalled. A redirect loads a new fetch PC and squashes any
// in-flight or buffered fetch. At most one memory access is outstanding.
//
// Ports
//   clk          single clock, rising edge
//   reset        synchronous, active-high
//   enable       1 = fetching permitted; 0 = finish current access then idle
//   stall        decode not accepting; the presented word is held
//   redirect     load redirect_pc as the next fetch PC this cycle
//   redirect_pc  new fetch PC (low two bits ignored)
//   mem_req      read request
//   mem_addr     read word address, stable while mem_req=1 until mem_gnt
//   mem_gnt      request accepted this cycle
//   mem_rvalid   read data valid (one response per grant)
//   mem_rdata    read data
//   insn         instruction presented to decode
//   pc           address of insn
//   valid_insn   insn/pc valid
// ---------------------------------------------------------------------------
module insn_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        valid_insn
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;  // hold buffer occupied
    localparam logic [2:0] S_DRAIN = 3'd4;  // squashed access still in flight

    logic [2:0]  r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_insn;
    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_hold_insn;
    logic [31:0] r_hold_pc;

    // State to enter once the current access is finished.
    logic [2:0]  w_resume;
    logic        w_consume;

    assign w_resume  = enable ? S_REQ : S_IDLE;
    assign w_consume = r_valid & ~stall;

    // NOTE: every register here is written with <= so all of them update
    // together from values sampled before the edge; a blocking = would let
    // later statements see half-updated state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_insn      <= 32'h0;
            r_pc        <= 32'h0;
            r_valid     <= 1'b0;
            r_hold_insn <= 32'h0;
            r_hold_pc   <= 32'h0;
        end else if (redirect) begin
            // Both the presented word and any held word are dropped, even
            // under stall. Leaving HOLD is what empties the hold buffer.
            r_fetch_pc <= redirect_pc & ~32'h3;
            r_valid    <= 1'b0;
            case (r_state)
                S_REQ:   r_state <= mem_gnt ? S_DRAIN : S_IDLE;
                S_WAIT:  r_state <= mem_rvalid ? w_resume : S_DRAIN;
                S_DRAIN: if (mem_rvalid) r_state <= w_resume;
                default: r_state <= w_resume;
            endcase
        end else begin
            // A consumed word goes invalid unless a new one loads below.
            if (w_consume) r_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (enable) r_state <= S_REQ;
                end
                S_REQ: begin
                    // Once granted the access always completes; enable=0
                    // only aborts a request that has not been granted.
                    if (mem_gnt) begin
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                        r_state    <= S_WAIT;
                    end else if (!enable) begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        if (!r_valid || !stall) begin
                            r_insn  <= mem_rdata;
                            r_pc    <= r_req_pc;
                            r_valid <= 1'b1;
                            r_state <= w_resume;
                        end else begin
                            r_hold_insn <= mem_rdata;
                            r_hold_pc   <= r_req_pc;
                            r_state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // The presented word is consumed on this same edge.
                    if (!stall) begin
                        r_insn  <= r_hold_insn;
                        r_pc    <= r_hold_pc;
                        r_valid <= 1'b1;
                        r_state <= w_resume;
                    end
                end
                S_DRAIN: begin
                    if (mem_rvalid) r_state <= w_resume;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req    = (r_state == S_REQ);
    assign mem_addr   = r_fetch_pc;
    assign insn       = r_insn;
    assign pc         = r_pc;
    assign valid_insn = r_valid;

endmodule
